// File: rtl/ip_sequencer.sv
// Fetch/issue/advance controller that owns instr_pointer.adj.
// Optional fetch watchdog: define IP_SEQ_TIMEOUT_EN.
module ip_sequencer #(
    parameter int WORD_WIDTH    = 16,
    parameter int INSTR_SIZE    = 1,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                  update_clk,
    input  logic                  reset_clk,
    input  logic [WORD_WIDTH-1:0] ip,
    output logic [WORD_WIDTH-1:0] ip_adj,
    output logic                  ip_step,
    input  logic                  halt,
    output logic                  fetch_req,
    output logic [WORD_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_ack,
    input  logic [WORD_WIDTH-1:0] fetch_data,
    output logic [WORD_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_valid,
    output logic                  branch_ready,
    input  logic [WORD_WIDTH-1:0] branch_offset,
    output logic                  fetch_err,
    output logic [1:0]            dbg_state
);

    if (FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 255) begin : g_bad_timeout
        $error("FETCH_TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  branch_pending_q, branch_pending_d;
    logic [WORD_WIDTH-1:0] branch_offset_q, branch_offset_d;
    logic                  fetch_gap;
    logic                  ack_take;
    logic                  branch_take;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.
    assign ack_take    = (state_q == ST_FETCH) && fetch_ack && !fetch_gap;
    assign branch_take = branch_valid && !branch_pending_q;

`ifdef IP_SEQ_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       fetch_err_q, fetch_err_d;

    // At the limit the request drops for one cycle, then reissues from a clear count.
    assign fetch_gap = (state_q == ST_FETCH) && (wdog_q == 8'(FETCH_TIMEOUT));

    always_comb begin
        wdog_d      = 8'd0;
        fetch_err_d = fetch_err_q;
        if ((state_q == ST_FETCH) && !ack_take && !fetch_gap) begin
            wdog_d = wdog_q + 8'd1;
        end
        if (fetch_gap) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            wdog_q      <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            wdog_q      <= wdog_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_gap = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!halt) state_d = ST_FETCH;
            ST_FETCH:   if (ack_take) state_d = ST_ISSUE;
            ST_ISSUE:   if (instr_ready) state_d = ST_ADVANCE;
            ST_ADVANCE: state_d = halt ? ST_IDLE : ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // A branch taken during ADVANCE sees pending_q low, so it survives to the next ADVANCE.
    always_comb begin
        instr_d          = ack_take ? fetch_data : instr_q;
        branch_offset_d  = branch_take ? branch_offset : branch_offset_q;
        branch_pending_d = branch_take || (branch_pending_q && (state_q != ST_ADVANCE));
    end

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) begin
            instr_q          <= '0;
            branch_offset_q  <= '0;
            branch_pending_q <= 1'b0;
        end else begin
            instr_q          <= instr_d;
            branch_offset_q  <= branch_offset_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    always_comb begin
        fetch_req   = 1'b0;
        instr_valid = 1'b0;
        ip_step     = 1'b0;
        ip_adj      = '0;
        case (state_q)
            ST_FETCH: fetch_req = !fetch_gap;
            ST_ISSUE: instr_valid = 1'b1;
            ST_ADVANCE: begin
                ip_step = 1'b1;
                ip_adj  = branch_pending_q ? branch_offset_q : WORD_WIDTH'(INSTR_SIZE);
            end
            default: ;
        endcase
    end

    assign fetch_addr   = ip;
    assign instr        = instr_q;
    assign branch_ready = !branch_pending_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Bench for ip_sequencer: an instr_pointer stand-in, an instruction-level
// reference model, directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_ip_sequencer;

    localparam int W = 16;

    logic         update_clk = 1'b0;
    logic         reset_clk  = 1'b0;
    logic [W-1:0] ip;
    logic [W-1:0] ip_init;
    logic [W-1:0] ip_adj;
    logic         ip_step;
    logic         halt;
    logic         fetch_req;
    logic [W-1:0] fetch_addr;
    logic         fetch_ack;
    logic [W-1:0] fetch_data;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic         instr_ready;
    logic         branch_valid;
    logic         branch_ready;
    logic [W-1:0] branch_offset;
    logic         fetch_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state: where the program is, and any accepted branch.
    logic [W-1:0] model_ip;
    bit           model_pending;
    logic [W-1:0] model_off;
    logic [W-1:0] exp_q[$];

    ip_sequencer #(.WORD_WIDTH(W), .INSTR_SIZE(1), .FETCH_TIMEOUT(15)) dut (
        .update_clk    (update_clk),
        .reset_clk     (reset_clk),
        .ip            (ip),
        .ip_adj        (ip_adj),
        .ip_step       (ip_step),
        .halt          (halt),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_data    (fetch_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_ready  (branch_ready),
        .branch_offset (branch_offset),
        .fetch_err     (fetch_err),
        .dbg_state     (dbg_state)
    );

    // Clock and the instr_pointer stand-in (adds adj on every edge).
    always #5 update_clk = ~update_clk;

    always_ff @(posedge update_clk or posedge reset_clk) begin
        if (reset_clk) ip <= ip_init;
        else           ip <= ip + ip_adj;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge update_clk);
        @(negedge update_clk);
    endtask

    // Called at a negedge; returns at a negedge in the first FETCH cycle.
    task automatic do_reset(input logic [W-1:0] init);
        ip_init       = init;
        halt          = 1'b0;
        fetch_ack     = 1'b0;
        fetch_data    = '0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_offset = '0;
        reset_clk     = 1'b1;
        #1;
        check("rst_ip_adj", ip_adj, 0);
        check("rst_ip_step", ip_step, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_branch_ready", branch_ready, 1);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_state", dbg_state, 0);
        @(negedge update_clk);
        reset_clk     = 1'b0;
        model_ip      = init;
        model_pending = 1'b0;
        model_off     = '0;
        exp_q.delete();
        check("rst_idle_after_release", dbg_state, 0);
        tick;
    endtask

    // One instruction from its first FETCH cycle through ADVANCE.
    task automatic do_instr(input int ack_dly, input int rdy_dly, input int br_cyc,
                            input logic [W-1:0] br_off, input bit halt_req);
        logic [W-1:0] addr;
        logic [W-1:0] word;
        logic [W-1:0] exp_adj;
        bit           adv;
        bit           rdy_now;
        int           total;
        int           j;
        addr    = model_ip;
        word    = mem_word(addr);
        total   = ack_dly + rdy_dly + 3;
        halt    = halt_req;
        exp_adj = '0;
        for (int cyc = 0; cyc < total; cyc++) begin
            adv     = (cyc == total - 1);
            rdy_now = !model_pending;
            check("ip_hold", ip, model_ip);
            check("branch_ready", branch_ready, rdy_now);
            check("ip_step", ip_step, adv);
            if (cyc <= ack_dly) begin
                check("fetch_req", fetch_req, 1);
                check("fetch_addr", fetch_addr, addr);
                check("instr_valid_fetch", instr_valid, 0);
                check("ip_adj_fetch", ip_adj, 0);
                fetch_ack   = (cyc == ack_dly);
                fetch_data  = (cyc == ack_dly) ? word : W'($urandom);
                instr_ready = 1'($urandom_range(0, 1));
                if (cyc == ack_dly) exp_q.push_back(word);
            end else if (!adv) begin
                j = cyc - ack_dly - 1;
                check("instr_valid_issue", instr_valid, 1);
                check("fetch_req_issue", fetch_req, 0);
                check("ip_adj_issue", ip_adj, 0);
                check("instr", instr, exp_q[0]);
                fetch_ack   = 1'($urandom_range(0, 1));
                fetch_data  = W'($urandom);
                instr_ready = (j == rdy_dly);
                if (j == rdy_dly) void'(exp_q.pop_front());
            end else begin
                exp_adj = model_pending ? model_off : W'(1);
                check("ip_adj_advance", ip_adj, exp_adj);
                check("instr_valid_advance", instr_valid, 0);
                check("fetch_req_advance", fetch_req, 0);
                fetch_ack     = 1'($urandom_range(0, 1));
                fetch_data    = W'($urandom);
                instr_ready   = 1'($urandom_range(0, 1));
                model_pending = 1'b0;
                model_ip      = model_ip + exp_adj;
            end
            branch_valid  = (cyc == br_cyc);
            branch_offset = (cyc == br_cyc) ? br_off : W'($urandom);
            if (branch_valid && rdy_now) begin
                model_pending = 1'b1;
                model_off     = br_off;
            end
            tick;
        end
        branch_valid = 1'b0;
        if (halt_req) begin
            fetch_ack  = 1'b1;
            fetch_data = W'($urandom);
            for (int k = 0; k < 2; k++) begin
                check("halt_idle", dbg_state, 0);
                check("halt_fetch_req", fetch_req, 0);
                check("halt_ip", ip, model_ip);
                tick;
            end
            halt      = 1'b0;
            fetch_ack = 1'b0;
            check("halt_release_idle", dbg_state, 0);
            tick;
        end
    endtask

    initial begin
        int ad, rd, bc, tot;
        halt = 1'b0; fetch_ack = 1'b0; fetch_data = '0; instr_ready = 1'b0;
        branch_valid = 1'b0; branch_offset = '0; ip_init = '0;
        @(negedge update_clk);

        // Sequential flow from ip=0, zero-wait memory and decoder.
        do_reset(16'd0);
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", fetch_addr, i);
            do_instr(0, 0, -1, '0, 1'b0);
        end

        // Backward branch accepted during ISSUE at ip=5.
        do_reset(16'd5);
        do_instr(0, 0, 1, 16'hFFFE, 1'b0);
        check("branch_target", fetch_addr, 3);
        do_instr(0, 0, -1, '0, 1'b0);

        // Branch accepted in ADVANCE at ip=2 applies one instruction later.
        do_reset(16'd2);
        do_instr(0, 0, 2, 16'd8, 1'b0);
        check("adv_branch_first", ip, 3);
        do_instr(0, 0, -1, '0, 1'b0);
        check("adv_branch_second", ip, 11);

        // Backpressure on both memory and decode.
        do_instr(4, 5, -1, '0, 1'b0);
        check("backpressure_ip", ip, 12);

        // Halt raised during FETCH at ip=7.
        do_reset(16'd7);
        do_instr(0, 0, -1, '0, 1'b1);
        check("halt_ip8", ip, 8);
        do_instr(1, 1, -1, '0, 1'b0);

        // Reset in the middle of ISSUE with a branch pending, then a late ack.
        do_reset(16'd40);
        fetch_ack = 1'b1; fetch_data = mem_word(16'd40);
        branch_valid = 1'b1; branch_offset = 16'd5; instr_ready = 1'b0;
        tick;
        branch_valid = 1'b0; fetch_ack = 1'b0;
        check("mid_issue_valid", instr_valid, 1);
        check("mid_issue_instr", instr, mem_word(16'd40));
        check("mid_issue_branch_ready", branch_ready, 0);
        #2;
        reset_clk = 1'b1;
        #1;
        check("async_rst_instr_valid", instr_valid, 0);
        check("async_rst_instr", instr, 0);
        check("async_rst_branch_ready", branch_ready, 1);
        check("async_rst_state", dbg_state, 0);
        check("async_rst_ip_adj", ip_adj, 0);
        fetch_ack = 1'b1; fetch_data = 16'hBEEF; halt = 1'b1;
        @(negedge update_clk);
        reset_clk = 1'b0;
        tick;
        check("late_ack_state", dbg_state, 0);
        check("late_ack_instr", instr, 0);
        check("late_ack_fetch_req", fetch_req, 0);
        halt = 1'b0; fetch_ack = 1'b0;
        model_ip = ip_init; model_pending = 1'b0; exp_q.delete();
        tick;
        do_instr(0, 0, -1, '0, 1'b0);
        check("post_reset_ip", ip, 41);

        // Address wrap-around.
        do_reset(16'hFFFE);
        do_instr(0, 0, -1, '0, 1'b0);
        do_instr(0, 0, -1, '0, 1'b0);
        check("wrap_addr", fetch_addr, 0);
        do_instr(0, 0, -1, '0, 1'b0);

        // Randomized run against the model.
        do_reset(W'($urandom));
        for (int n = 0; n < 40; n++) begin
            ad  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            tot = ad + rd + 3;
            bc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            do_instr(ad, rd, bc, W'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Fetch watchdog.
        do_reset(16'h0020);
        fetch_ack = 1'b0;
`ifdef IP_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            check("to_fetch_req", fetch_req, (k != 16));
            check("to_fetch_addr", fetch_addr, 16'h0020);
            check("to_fetch_err", fetch_err, (k >= 17));
            check("to_state", dbg_state, 1);
            tick;
        end
        do_instr(0, 0, -1, '0, 1'b0);
        check("to_err_sticky", fetch_err, 1);
`else
        for (int k = 1; k <= 20; k++) begin
            check("wait_fetch_req", fetch_req, 1);
            check("wait_fetch_err", fetch_err, 0);
            tick;
        end
        do_instr(0, 0, -1, '0, 1'b0);
`endif
        do_reset(16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
